// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with load-use hazard detection.
// Define HAZARD_STATS_EN to add the stall_cnt/flush_cnt counter outputs.
`ifndef OPCODE_LOAD
`define OPCODE_LOAD   5'b00000
`endif
`ifndef OPCODE_OP_IMM
`define OPCODE_OP_IMM 5'b00100
`endif
`ifndef OPCODE_AUIPC
`define OPCODE_AUIPC  5'b00101
`endif
`ifndef OPCODE_STORE
`define OPCODE_STORE  5'b01000
`endif
`ifndef OPCODE_ARITH_R
`define OPCODE_ARITH_R 5'b01100
`endif
`ifndef OPCODE_LUI
`define OPCODE_LUI    5'b01101
`endif
`ifndef OPCODE_BRANCH
`define OPCODE_BRANCH 5'b11000
`endif
`ifndef OPCODE_JALR
`define OPCODE_JALR   5'b11001
`endif
`ifndef OPCODE_JAL
`define OPCODE_JAL    5'b11011
`endif

module id_ex_stage_reg #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 11,
  parameter int RA_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [4:0]        id_opcode,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [RA_W-1:0]   id_rs1,
  input  logic [RA_W-1:0]   id_rs2,
  input  logic [RA_W-1:0]   id_rd,
  input  logic [3:0]        id_func,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              stall_o,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [RA_W-1:0]   ex_rs1,
  output logic [RA_W-1:0]   ex_rs2,
  output logic [RA_W-1:0]   ex_rd,
  output logic [3:0]        ex_func
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  localparam int MEMREAD = CTRL_W - 2;

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_rs1_data;
  logic [XLEN-1:0]   r_rs2_data;
  logic [XLEN-1:0]   r_imm;
  logic [RA_W-1:0]   r_rs1;
  logic [RA_W-1:0]   r_rs2;
  logic [RA_W-1:0]   r_rd;
  logic [3:0]        r_func;

  logic w_uses_rs1;
  logic w_uses_rs2;
  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_load_use;
  logic w_bubble;

  assign w_uses_rs1 = !((id_opcode == `OPCODE_JAL) ||
                        (id_opcode == `OPCODE_LUI) ||
                        (id_opcode == `OPCODE_AUIPC));
  assign w_uses_rs2 = (id_opcode == `OPCODE_ARITH_R) ||
                      (id_opcode == `OPCODE_STORE) ||
                      (id_opcode == `OPCODE_BRANCH);

  assign w_rs1_hit  = w_uses_rs1 && (r_rd == id_rs1);
  assign w_rs2_hit  = w_uses_rs2 && (r_rd == id_rs2);
  assign w_load_use = r_valid && r_ctrl[MEMREAD] &&
                      (r_rd != '0) && id_valid &&
                      (w_rs1_hit || w_rs2_hit);

  // A redirect must be accepted, so flush masks the hazard stall.
  assign stall_o  = ex_hold || (w_load_use && !flush);
  assign w_bubble = !flush && !ex_hold && w_load_use;

  // Stage register: flush > hold > load-use bubble > advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_ctrl     <= '0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_func     <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (ex_hold) begin
      r_valid <= r_valid;
    end else if (w_load_use) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else begin
      r_valid    <= id_valid;
      r_ctrl     <= id_valid ? id_ctrl : '0;
      r_pc       <= id_pc;
      r_rs1_data <= id_rs1_data;
      r_rs2_data <= id_rs2_data;
      r_imm      <= id_imm;
      r_rs1      <= id_rs1;
      r_rs2      <= id_rs2;
      r_rd       <= id_rd;
      r_func     <= id_func;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Hazard statistics; both counters wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_bubble) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (flush)    r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

  assign ex_valid    = r_valid;
  assign ex_ctrl     = r_ctrl;
  assign ex_pc       = r_pc;
  assign ex_rs1_data = r_rs1_data;
  assign ex_rs2_data = r_rs2_data;
  assign ex_imm      = r_imm;
  assign ex_rs1      = r_rs1;
  assign ex_rs2      = r_rs2;
  assign ex_rd       = r_rd;
  assign ex_func     = r_func;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: directed table, corner sequences and
// randomized traffic against a spec-level reference model.
`timescale 1ns/1ps
module tb_id_ex_stage_reg;

  localparam logic [4:0] OP_LD  = 5'b00000;
  localparam logic [4:0] OP_IMM = 5'b00100;
  localparam logic [4:0] OP_AUI = 5'b00101;
  localparam logic [4:0] OP_ST  = 5'b01000;
  localparam logic [4:0] OP_R   = 5'b01100;
  localparam logic [4:0] OP_LUI = 5'b01101;
  localparam logic [4:0] OP_BR  = 5'b11000;
  localparam logic [4:0] OP_JR  = 5'b11001;
  localparam logic [4:0] OP_JAL = 5'b11011;

  localparam logic [10:0] C_R   = 11'b00010001000;
  localparam logic [10:0] C_LW  = 11'b01100011000;
  localparam logic [10:0] C_LUI = 11'b00000011011;
  localparam logic [10:0] C_IMM = 11'b00010011000;
  localparam logic [10:0] C_SW  = 11'b00000110000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid;
  logic [4:0] id_opcode;
  logic [10:0] id_ctrl;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [3:0] id_func;
  logic flush, ex_hold;
  logic stall_o, ex_valid;
  logic [10:0] ex_ctrl;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [3:0] ex_func;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_opcode(id_opcode),
    .id_ctrl(id_ctrl), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_func(id_func),
    .flush(flush), .ex_hold(ex_hold),
    .stall_o(stall_o), .ex_valid(ex_valid),
    .ex_ctrl(ex_ctrl), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_func(ex_func)
`ifdef HAZARD_STATS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] op,
                       input logic [10:0] c, input logic [31:0] pc,
                       input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] d, input logic fl,
                       input logic hd);
    id_valid = v; id_opcode = op; id_ctrl = c; id_pc = pc;
    id_rs1_data = pc ^ 32'hA5A5_0001;
    id_rs2_data = pc ^ 32'h5A5A_0002;
    id_imm = ~pc;
    id_rs1 = s1; id_rs2 = s2; id_rd = d;
    id_func = pc[5:2];
    flush = fl; ex_hold = hd;
  endtask

  typedef struct {
    logic v; logic [4:0] op; logic [10:0] c; logic [31:0] pc;
    logic [4:0] s1, s2, d; logic fl, hd;
    logic e_stall, e_valid; logic [10:0] e_ctrl; logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[20];

  // Reference model state: what EX should hold.
  typedef struct {
    logic v; logic [10:0] c; logic [31:0] pc, d1, d2, imm;
    logic [4:0] s1, s2, d; logic [3:0] f;
  } ex_t;
  ex_t m;
  int unsigned m_stalls, m_flushes;

  function automatic bit reads_rs1(input logic [4:0] op);
    return !(op inside {OP_JAL, OP_LUI, OP_AUI});
  endfunction

  function automatic bit reads_rs2(input logic [4:0] op);
    return op inside {OP_R, OP_ST, OP_BR};
  endfunction

  function automatic bit hazard();
    bit dep;
    dep = (reads_rs1(id_opcode) && m.d == id_rs1) ||
          (reads_rs2(id_opcode) && m.d == id_rs2);
    return m.v && m.c[9] && m.d != 0 && id_valid && dep;
  endfunction

  task automatic model_edge();
    bit hz;
    hz = hazard();
    if (flush) m_flushes++;
    if (flush || (!ex_hold && hz)) begin
      if (!flush) m_stalls++;
      m.v = 1'b0; m.c = '0;
    end else if (!ex_hold) begin
      m = '{id_valid, id_valid ? id_ctrl : 11'd0, id_pc,
            id_rs1_data, id_rs2_data, id_imm,
            id_rs1, id_rs2, id_rd, id_func};
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".valid"}, {31'd0, ex_valid}, {31'd0, m.v});
    chk({tag, ".ctrl"}, {21'd0, ex_ctrl}, {21'd0, m.c});
    if (m.v) begin
      chk({tag, ".pc"}, ex_pc, m.pc);
      chk({tag, ".d1"}, ex_rs1_data, m.d1);
      chk({tag, ".d2"}, ex_rs2_data, m.d2);
      chk({tag, ".imm"}, ex_imm, m.imm);
      chk({tag, ".regs"}, {17'd0, ex_rs1, ex_rs2, ex_rd},
          {17'd0, m.s1, m.s2, m.d});
      chk({tag, ".func"}, {28'd0, ex_func}, {28'd0, m.f});
    end
`ifdef HAZARD_STATS_EN
    chk({tag, ".scnt"}, stall_cnt, m_stalls);
    chk({tag, ".fcnt"}, flush_cnt, m_flushes);
`endif
  endtask

  logic [4:0] ops[9];

  initial begin
    ops = '{OP_LD, OP_IMM, OP_AUI, OP_ST, OP_R,
            OP_LUI, OP_BR, OP_JR, OP_JAL};
    drive(0, OP_R, 0, 0, 0, 0, 0, 0, 0);

    //     v op      ctrl   pc     s1 s2 d  fl hd  stl val ctrl   pc
    tbl[0]  = '{1, OP_R,   C_R,   'h100, 1, 2, 6, 0, 0, 0, 1, C_R,   'h100};
    tbl[1]  = '{1, OP_LD,  C_LW,  'h104, 1, 0, 5, 0, 0, 0, 1, C_LW,  'h104};
    tbl[2]  = '{1, OP_R,   C_R,   'h108, 5, 1, 6, 0, 0, 1, 0, 0,     'h104};
    tbl[3]  = '{1, OP_R,   C_R,   'h108, 5, 1, 6, 0, 0, 0, 1, C_R,   'h108};
    tbl[4]  = '{1, OP_LD,  C_LW,  'h10c, 1, 0, 5, 0, 0, 0, 1, C_LW,  'h10c};
    tbl[5]  = '{1, OP_LUI, C_LUI, 'h110, 5, 5, 5, 0, 0, 0, 1, C_LUI, 'h110};
    tbl[6]  = '{1, OP_LD,  C_LW,  'h114, 1, 0, 5, 0, 0, 0, 1, C_LW,  'h114};
    tbl[7]  = '{1, OP_IMM, C_IMM, 'h118, 1, 5, 7, 0, 0, 0, 1, C_IMM, 'h118};
    tbl[8]  = '{1, OP_LD,  C_LW,  'h11c, 1, 0, 0, 0, 0, 0, 1, C_LW,  'h11c};
    tbl[9]  = '{1, OP_R,   C_R,   'h120, 0, 0, 6, 0, 0, 0, 1, C_R,   'h120};
    tbl[10] = '{0, OP_R,   C_R,   'h124, 1, 2, 6, 0, 0, 0, 0, 0,     'h124};
    tbl[11] = '{1, OP_LD,  C_LW,  'h128, 1, 0, 5, 0, 0, 0, 1, C_LW,  'h128};
    tbl[12] = '{1, OP_ST,  C_SW,  'h12c, 1, 5, 0, 0, 0, 1, 0, 0,     'h128};
    tbl[13] = '{1, OP_LD,  C_LW,  'h130, 1, 0, 5, 0, 0, 0, 1, C_LW,  'h130};
    tbl[14] = '{1, OP_R,   C_R,   'h134, 5, 1, 6, 1, 0, 0, 0, 0,     'h130};
    tbl[15] = '{1, OP_LD,  C_LW,  'h138, 1, 0, 5, 0, 0, 0, 1, C_LW,  'h138};
    tbl[16] = '{1, OP_R,   C_R,   'h13c, 5, 1, 6, 0, 1, 1, 1, C_LW,  'h138};
    tbl[17] = '{1, OP_R,   C_R,   'h140, 5, 1, 6, 0, 1, 1, 1, C_LW,  'h138};
    tbl[18] = '{1, OP_R,   C_R,   'h144, 5, 1, 6, 0, 1, 1, 1, C_LW,  'h138};
    tbl[19] = '{1, OP_R,   C_R,   'h148, 1, 2, 6, 0, 0, 0, 1, C_R,   'h148};

    #12;
    chk("rst.valid", {31'd0, ex_valid}, 32'd0);
    chk("rst.ctrl", {21'd0, ex_ctrl}, 32'd0);
    chk("rst.pc", ex_pc, 32'd0);
    chk("rst.stall", {31'd0, stall_o}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].v, tbl[i].op, tbl[i].c, tbl[i].pc,
            tbl[i].s1, tbl[i].s2, tbl[i].d, tbl[i].fl, tbl[i].hd);
      #1;
      chk($sformatf("vec%0d.stall", i), {31'd0, stall_o},
          {31'd0, tbl[i].e_stall});
      @(posedge clk); #1;
      chk($sformatf("vec%0d.valid", i), {31'd0, ex_valid},
          {31'd0, tbl[i].e_valid});
      chk($sformatf("vec%0d.ctrl", i), {21'd0, ex_ctrl},
          {21'd0, tbl[i].e_ctrl});
      chk($sformatf("vec%0d.pc", i), ex_pc, tbl[i].e_pc);
    end
`ifdef HAZARD_STATS_EN
    chk("tbl.scnt", stall_cnt, 32'd2);
    chk("tbl.fcnt", flush_cnt, 32'd1);
`endif

    // Asynchronous reset while a load-use stall is pending.
    drive(1, OP_LD, C_LW, 'h200, 1, 0, 5, 0, 0);
    @(posedge clk); #1;
    drive(1, OP_R, C_R, 'h204, 5, 1, 6, 0, 0);
    #1;
    chk("arst.pre", {31'd0, stall_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.stall", {31'd0, stall_o}, 32'd0);
    chk("arst.valid", {31'd0, ex_valid}, 32'd0);
    chk("arst.ctrl", {21'd0, ex_ctrl}, 32'd0);
    chk("arst.pc", ex_pc, 32'd0);
    chk("arst.rd", {27'd0, ex_rd}, 32'd0);
`ifdef HAZARD_STATS_EN
    chk("arst.scnt", stall_cnt, 32'd0);
    chk("arst.fcnt", flush_cnt, 32'd0);
`endif
    #1 rst_n = 1'b1;
    m = '{1'b0, 11'd0, 32'd0, 32'd0, 32'd0, 32'd0,
          5'd0, 5'd0, 5'd0, 4'd0};
    m_stalls = 0;
    m_flushes = 0;

    // Randomized traffic with small register indices to force hazards.
    for (int n = 0; n < 400; n++) begin
      logic [10:0] c;
      c = 11'($urandom);
      if ($urandom_range(0, 1) == 0) c[9] = 1'b1;
      drive($urandom_range(0, 9) != 0,
            ops[$urandom_range(0, 8)], c, $urandom,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 6) == 0);
      id_rs1_data = $urandom;
      id_rs2_data = $urandom;
      id_imm = $urandom;
      id_func = 4'($urandom);
      #1;
      chk($sformatf("rnd%0d.stall", n), {31'd0, stall_o},
          {31'd0, ex_hold || (hazard() && !flush)});
      model_edge();
      @(posedge clk); #1;
      chk_model($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
